// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the memory-access stage.
//
// Contents:
//   REG_WIDTH, NUM_REGS : default datapath width and register count
//   commit_t            : memory-control flags of a commit packet
//   writeback_t         : writeback-control flags of a commit packet
//   mem_state_e         : state encoding of the memory-access FSM
package cpu_pkg;

    localparam int REG_WIDTH = 32;
    localparam int NUM_REGS  = 32;

    typedef struct packed {
        logic mem_write;
        logic mem_read;
    } commit_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } writeback_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/cpu_mem_stage.sv
// Memory-access pipeline stage.
//
// Takes one commit packet per in_valid/in_ready handshake, performs any
// load or store over the data-memory port, and emits a registered one-cycle
// writeback pulse. Non-memory packets pass through at one per cycle.
//
// Handshake semantics (both the upstream port and the dmem request port):
// a transfer happens on a rising edge where valid and ready are both high;
// the sender keeps valid and its payload stable until that edge, and ready
// may depend on state only (never combinationally on valid).
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready        upstream commit handshake
//   in_mem_write, in_mem_read  store / load request (both set = store)
//   in_mem_to_reg, in_reg_write writeback source select / write enable
//   in_alu_result, in_rb_data  address-or-result, store data
//   in_reg_dest                destination register
//   dmem_req_*                 data-memory request (valid/ready)
//   dmem_rsp_valid/_data       read response, only observed in WAIT_RSP
//   wb_*                       writeback packet, wb_valid is a 1-cycle pulse
//   err_timeout                sticky flag: a read response timed out
//   dbg_state                  current FSM state (mem_state_e encoding)
module cpu_mem_stage #(
    parameter int REG_WIDTH   = cpu_pkg::REG_WIDTH,
    parameter int NUM_REGS    = cpu_pkg::NUM_REGS,
    parameter int RSP_TIMEOUT = 256,
    localparam int RD_W       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mem_write,
    input  logic                 in_mem_read,
    input  logic                 in_mem_to_reg,
    input  logic                 in_reg_write,
    input  logic [REG_WIDTH-1:0] in_alu_result,
    input  logic [REG_WIDTH-1:0] in_rb_data,
    input  logic [RD_W-1:0]      in_reg_dest,
    output logic                 dmem_req_valid,
    input  logic                 dmem_req_ready,
    output logic                 dmem_req_we,
    output logic [REG_WIDTH-1:0] dmem_req_addr,
    output logic [REG_WIDTH-1:0] dmem_req_wdata,
    input  logic                 dmem_rsp_valid,
    input  logic [REG_WIDTH-1:0] dmem_rsp_data,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [RD_W-1:0]      wb_reg_dest,
    output logic [REG_WIDTH-1:0] wb_data,
    output logic                 err_timeout,
    output logic [1:0]           dbg_state
);

    import cpu_pkg::*;

    // A timeout of 1 still needs a 1-bit counter.
    localparam int CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RSP_TIMEOUT - 1);

    mem_state_e state_q, state_d;

    // Latched packet
    commit_t              cmt_q;
    writeback_t           wbc_q;
    logic [REG_WIDTH-1:0] alu_q;
    logic [REG_WIDTH-1:0] rb_q;
    logic [RD_W-1:0]      dest_q;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic                 wb_valid_q, wb_valid_d;
    logic                 wb_rw_q, wb_rw_d;
    logic [RD_W-1:0]      wb_dest_q, wb_dest_d;
    logic [REG_WIDTH-1:0] wb_data_q, wb_data_d;

    logic accept;
    logic in_is_mem;
    logic req_fire;
    logic rsp_hit;
    logic timeout_hit;

    assign accept      = in_valid && (state_q == IDLE);
    assign in_is_mem   = in_mem_write || in_mem_read;
    assign req_fire    = (state_q == REQ) && dmem_req_ready;
    assign rsp_hit     = (state_q == WAIT_RSP) && dmem_rsp_valid;
    // A response in the final waiting cycle wins over the timeout.
    assign timeout_hit = (state_q == WAIT_RSP) && !dmem_rsp_valid && (cnt_q == CNT_MAX);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && in_is_mem) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dmem_req_ready) begin
                    state_d = cmt_q.mem_write ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rsp_hit || timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        in_ready       = (state_q == IDLE);
        dmem_req_valid = 1'b0;
        dmem_req_we    = 1'b0;
        dmem_req_addr  = '0;
        dmem_req_wdata = '0;
        if (state_q == REQ) begin
            dmem_req_valid = 1'b1;
            dmem_req_we    = cmt_q.mem_write;
            dmem_req_addr  = alu_q;
            dmem_req_wdata = rb_q;
        end
    end

    assign dbg_state = state_q;

    // ---------------------------------------------------------------
    // Packet latch
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmt_q  <= '0;
            wbc_q  <= '0;
            alu_q  <= '0;
            rb_q   <= '0;
            dest_q <= '0;
        end else if (accept) begin
            cmt_q  <= '{mem_write: in_mem_write, mem_read: in_mem_read};
            wbc_q  <= '{mem_to_reg: in_mem_to_reg, reg_write: in_reg_write};
            alu_q  <= in_alu_result;
            rb_q   <= in_rb_data;
            dest_q <= in_reg_dest;
        end
    end

    // ---------------------------------------------------------------
    // Writeback, timeout counter and sticky error
    // ---------------------------------------------------------------
    always_comb begin
        wb_valid_d = 1'b0;
        wb_rw_d    = wb_rw_q;
        wb_dest_d  = wb_dest_q;
        wb_data_d  = wb_data_q;
        cnt_d      = cnt_q;
        err_d      = err_q;

        if (req_fire) begin
            cnt_d = '0;
        end else if (state_q == WAIT_RSP) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (accept && !in_is_mem) begin
            // Pass-through: the bypass uses the live inputs, not the latch.
            wb_valid_d = 1'b1;
            wb_rw_d    = in_reg_write;
            wb_dest_d  = in_reg_dest;
            wb_data_d  = in_alu_result;
        end else if (req_fire && cmt_q.mem_write) begin
            wb_valid_d = 1'b1;
            wb_rw_d    = wbc_q.reg_write;
            wb_dest_d  = dest_q;
            wb_data_d  = alu_q;
        end else if (rsp_hit) begin
            wb_valid_d = 1'b1;
            wb_rw_d    = wbc_q.reg_write;
            wb_dest_d  = dest_q;
            wb_data_d  = wbc_q.mem_to_reg ? dmem_rsp_data : alu_q;
        end else if (timeout_hit) begin
            // Retire the packet so the pipeline moves on, but never write
            // a register with data that did not arrive.
            wb_valid_d = 1'b1;
            wb_rw_d    = 1'b0;
            wb_dest_d  = dest_q;
            wb_data_d  = alu_q;
            err_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_dest_q  <= wb_dest_d;
            wb_data_q  <= wb_data_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_rw_q;
    assign wb_reg_dest  = wb_dest_q;
    assign wb_data      = wb_data_q;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_cpu_mem_stage.sv
// Testbench for cpu_mem_stage (RSP_TIMEOUT = 4).
module tb_cpu_mem_stage;

    localparam int W  = 32;
    localparam int RD = 5;
    localparam int TO = 4;

    typedef struct packed {
        logic          chk_data;
        logic          rw;
        logic [RD-1:0] dest;
        logic [W-1:0]  data;
    } wb_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          in_valid, in_ready;
    logic          in_mem_write, in_mem_read, in_mem_to_reg, in_reg_write;
    logic [W-1:0]  in_alu_result, in_rb_data;
    logic [RD-1:0] in_reg_dest;
    logic          dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [W-1:0]  dmem_req_addr, dmem_req_wdata;
    logic          dmem_rsp_valid;
    logic [W-1:0]  dmem_rsp_data;
    logic          wb_valid, wb_reg_write;
    logic [RD-1:0] wb_reg_dest;
    logic [W-1:0]  wb_data;
    logic          err_timeout;
    logic [1:0]    dbg_state;

    cpu_mem_stage #(.REG_WIDTH(W), .NUM_REGS(32), .RSP_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_alu_result(in_alu_result), .in_rb_data(in_rb_data),
        .in_reg_dest(in_reg_dest),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_reg_dest(wb_reg_dest), .wb_data(wb_data),
        .err_timeout(err_timeout), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    wb_t  exp_q[$];
    wb_t  got_q[$];
    int   got_cyc[$];
    logic exp_err = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            got_q.push_back({1'b1, wb_reg_write, wb_reg_dest, wb_data});
            got_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_wb(input string tag);
        int n;
        chk({tag, "_wb_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_wb_dest"}, 64'(got_q[i].dest), 64'(exp_q[i].dest));
            chk({tag, "_wb_rw"},   64'(got_q[i].rw),   64'(exp_q[i].rw));
            if (exp_q[i].chk_data)
                chk({tag, "_wb_data"}, 64'(got_q[i].data), 64'(exp_q[i].data));
        end
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic drive_pkt(input logic we, input logic re, input logic mtr, input logic rw,
                             input logic [W-1:0] alu, input logic [W-1:0] rb, input logic [RD-1:0] dest);
        in_valid      = 1'b1;
        in_mem_write  = we;
        in_mem_read   = re;
        in_mem_to_reg = mtr;
        in_reg_write  = rw;
        in_alu_result = alu;
        in_rb_data    = rb;
        in_reg_dest   = dest;
    endtask

    // n back-to-back ALU packets; each writes back alu on the following cycle.
    task automatic alu_burst(input int n, input logic [W-1:0] base, input logic [RD-1:0] dbase,
                             input logic rw, input string tag);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
            drive_pkt(1'b0, 1'b0, 1'b0, rw, base + W'(i), W'($urandom), dbase + RD'(i));
            exp_q.push_back({1'b1, rw, dbase + RD'(i), base + W'(i)});
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        for (int i = 1; i < got_cyc.size(); i++)
            chk({tag, "_wb_consecutive"}, 64'(got_cyc[i]), 64'(got_cyc[0] + i));
        compare_wb(tag);
        @(negedge clk);
        chk({tag, "_wb_pulse_end"}, 64'(wb_valid), 64'd0);
        chk({tag, "_wb_data_hold"}, 64'(wb_data), 64'(base + W'(n - 1)));
    endtask

    // One memory packet. rdly: cycles before dmem_req_ready; rsp_dly: WAIT cycle
    // index of the response (-1 or >=TO means none); noise: raise rsp_valid
    // during REQ (must be ignored); pend: hold a follow-on ALU packet on the
    // input while the stage is busy.
    task automatic mem_op(input logic we, input logic re, input logic mtr, input logic rw,
                          input logic [W-1:0] alu, input logic [W-1:0] rb, input logic [RD-1:0] dest,
                          input int rdly, input int rsp_dly, input logic [W-1:0] rsp_data,
                          input bit noise, input bit pend, input string tag);
        bit timed_out;
        logic [W-1:0] p_alu;
        p_alu = W'($urandom);
        timed_out = 1'b0;
        chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        drive_pkt(we, re, mtr, rw, alu, rb, dest);
        @(negedge clk);
        if (pend) drive_pkt(1'b0, 1'b0, 1'b0, 1'b1, p_alu, '0, 5'd9);
        else      in_valid = 1'b0;
        for (int i = 0; i <= rdly; i++) begin
            chk({tag, "_req_valid"}, 64'(dmem_req_valid), 64'd1);
            chk({tag, "_req_addr"},  64'(dmem_req_addr),  64'(alu));
            chk({tag, "_req_wdata"}, 64'(dmem_req_wdata), 64'(rb));
            chk({tag, "_req_we"},    64'(dmem_req_we),    64'(we));
            chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
            dmem_req_ready = (i == rdly);
            dmem_rsp_valid = noise;
            dmem_rsp_data  = W'($urandom);
            @(negedge clk);
        end
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        if (!we) begin
            timed_out = 1'b1;
            for (int k = 0; k < TO; k++) begin
                chk({tag, "_wait_req_valid"}, 64'(dmem_req_valid), 64'd0);
                chk({tag, "_in_ready_wait"},  64'(in_ready), 64'd0);
                if (k == rsp_dly) begin
                    dmem_rsp_valid = 1'b1;
                    dmem_rsp_data  = rsp_data;
                end
                @(negedge clk);
                dmem_rsp_valid = 1'b0;
                if (k == rsp_dly) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        chk({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
        // Reference rules: stores retire with alu; loads with a response pick
        // memory or alu by mem_to_reg; a timed-out load never writes.
        if (we)             exp_q.push_back({1'b1, rw, dest, alu});
        else if (timed_out) begin
            exp_q.push_back({1'b0, 1'b0, dest, alu});
            exp_err = 1'b1;
        end else            exp_q.push_back({1'b1, rw, dest, mtr ? rsp_data : alu});
        if (pend) begin
            exp_q.push_back({1'b1, 1'b1, 5'd9, p_alu});
            @(negedge clk);
            in_valid = 1'b0;
        end
        #1;
        compare_wb(tag);
        chk({tag, "_err_timeout"}, 64'(err_timeout), 64'(exp_err));
        @(negedge clk);
        chk({tag, "_wb_pulse_end"}, 64'(wb_valid), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready), 64'd1);
        chk({tag, "_req_valid"}, 64'(dmem_req_valid), 64'd0);
        chk({tag, "_req_we"},    64'(dmem_req_we), 64'd0);
        chk({tag, "_req_addr"},  64'(dmem_req_addr), 64'd0);
        chk({tag, "_req_wdata"}, 64'(dmem_req_wdata), 64'd0);
        chk({tag, "_wb_valid"},  64'(wb_valid), 64'd0);
        chk({tag, "_wb_rw"},     64'(wb_reg_write), 64'd0);
        chk({tag, "_wb_dest"},   64'(wb_reg_dest), 64'd0);
        chk({tag, "_wb_data"},   64'(wb_data), 64'd0);
        chk({tag, "_err"},       64'(err_timeout), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_mem_write = 1'b0; in_mem_read = 1'b0;
        in_mem_to_reg = 1'b0; in_reg_write = 1'b0;
        in_alu_result = '0; in_rb_data = '0; in_reg_dest = '0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_data = '0;
        #1;
        check_reset_outputs("reset_init");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // ALU ops back-to-back
        alu_burst(4, 32'h10, 5'd5, 1'b1, "alu_b2b");

        // Store, ready delayed 3 cycles
        mem_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 5'd1,
               3, -1, '0, 1'b0, 1'b0, "store_delay");

        // Load, immediate ready, response 2 cycles into WAIT_RSP, with a
        // follow-on packet waiting upstream
        mem_op(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 32'h0, 5'd3,
               0, 2, 32'hCAFEF00D, 1'b0, 1'b1, "load_basic");

        // Both flags set behaves as a store
        mem_op(1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 32'h12345678, 5'd7,
               1, -1, '0, 1'b1, 1'b0, "store_both");

        // Response exactly on the timeout cycle
        mem_op(1'b0, 1'b1, 1'b1, 1'b1, 32'h400, 32'h0, 5'd4,
               0, TO - 1, 32'h0BADF00D, 1'b0, 1'b0, "load_edge");

        // Load timeout, then a stray response
        mem_op(1'b0, 1'b1, 1'b1, 1'b1, 32'h500, 32'h0, 5'd6,
               0, -1, '0, 1'b0, 1'b0, "load_timeout");
        dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h55AA55AA;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        compare_wb("stray_after_timeout");
        chk("err_sticky", 64'(err_timeout), 64'd1);

        // Asynchronous reset in the middle of WAIT_RSP
        drive_pkt(1'b0, 1'b1, 1'b1, 1'b1, 32'h600, 32'h0, 5'd2);
        dmem_req_ready = 1'b1;
        @(negedge clk);                 // REQ, handshake at next edge
        in_valid = 1'b0;
        @(negedge clk);                 // WAIT_RSP cycle 0
        dmem_req_ready = 1'b0;
        @(negedge clk);                 // WAIT_RSP cycle 1
        chk("pre_reset_busy", 64'(in_ready), 64'd0);
        #2 reset = 1'b1;
        exp_err = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'hFEEDFACE;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        #1;
        compare_wb("stray_after_reset");
        chk("after_reset_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Randomized mix against the reference rules
        for (int t = 0; t < 30; t++) begin
            int kind;
            int rd;
            kind = $urandom_range(0, 2);
            rd   = $urandom_range(0, TO + 1);
            if (rd >= TO) rd = -1;
            case (kind)
                0: alu_burst($urandom_range(1, 3), W'($urandom), RD'($urandom), 1'($urandom), "rnd_alu");
                1: mem_op(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), W'($urandom), W'($urandom),
                          RD'($urandom), $urandom_range(0, 3), -1, '0, 1'($urandom), 1'($urandom), "rnd_store");
                default: mem_op(1'b0, 1'b1, 1'($urandom), 1'($urandom), W'($urandom), W'($urandom),
                                RD'($urandom), $urandom_range(0, 3), rd, W'($urandom),
                                1'($urandom), 1'($urandom), "rnd_load");
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_mem_stage.md
Name: cpu_mem_stage

Overview:
Memory-access stage directly downstream of the execute-to-commit bundle. It consumes one commit packet per handshake: control flags, ALU result, store data and destination register. It performs any load/store over a valid/ready data-memory port with variable response latency, then emits a registered one-cycle writeback packet to the register file. The stage stalls upstream via in_ready while a memory access is in flight.

Parameters:
REG_WIDTH, 32, datapath/address width
NUM_REGS, 32, register count; dest index width RD_W = $clog2(NUM_REGS)
RSP_TIMEOUT, 256, max cycles in WAIT_RSP before abort (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  commit packet valid
in_ready  out  1  stage can accept packet
in_mem_write  in  1  store
in_mem_read  in  1  load
in_mem_to_reg  in  1  writeback selects memory data
in_reg_write  in  1  writeback enable
in_alu_result  in  REG_WIDTH  ALU result / memory address
in_rb_data  in  REG_WIDTH  store data
in_reg_dest  in  RD_W  destination register
dmem_req_valid  out  1  memory request valid
dmem_req_ready  in  1  memory accepts request
dmem_req_we  out  1  1 = write
dmem_req_addr  out  REG_WIDTH  address
dmem_req_wdata  out  REG_WIDTH  write data
dmem_rsp_valid  in  1  read data valid
dmem_rsp_data  in  REG_WIDTH  read data
wb_valid  out  1  writeback packet valid, one-cycle pulse
wb_reg_write  out  1  register write enable
wb_reg_dest  out  RD_W  destination register
wb_data  out  REG_WIDTH  value to write
err_timeout  out  1  sticky: a read response timed out

Behaviour:
- Reset (async, active-high) sets all of the following, and takes priority mid-transaction:
  - state = IDLE.
  - All outputs 0, except in_ready, which is 1 (it follows IDLE).
  - Timeout counter = 0.
  - err_timeout cleared.
- FSM states: IDLE, REQ, WAIT_RSP.
- in_ready = (state == IDLE). A packet is accepted on in_valid & in_ready. All in_* fields are latched into an internal register on accept.
- IDLE, accepting a non-memory packet (mem_read = mem_write = 0):
  - Stay in IDLE.
  - Next cycle: wb_valid = 1, wb_data = latched alu_result, wb_reg_write/wb_reg_dest from the packet.
  - Throughput is 1 packet per cycle, latency 1.
- IDLE, accepting a memory packet: go to REQ.
  - If both mem_write and mem_read are set, the packet is treated as a store.
- REQ:
  - dmem_req_valid = 1, addr = latched alu_result, wdata = latched rb_data, we = latched mem_write.
  - Request fields are held stable until dmem_req_ready.
  - On handshake, a store goes to IDLE and pulses wb_valid the next cycle (wb_data = alu_result; wb_reg_write as latched).
  - On handshake, a load goes to WAIT_RSP and clears the counter.
- WAIT_RSP:
  - dmem_req_valid = 0. The counter increments each cycle.
  - On dmem_rsp_valid: go to IDLE. Next cycle wb_valid = 1 and wb_data = (mem_to_reg ? dmem_rsp_data : alu_result).
  - If the counter reaches RSP_TIMEOUT-1 without a response: go to IDLE, set err_timeout, and emit wb_valid with wb_reg_write forced to 0.
  - A response arriving in the same cycle as the timeout wins; err_timeout is not set.
- dmem_rsp_valid is ignored in IDLE and REQ. No response is expected for stores.
- wb_valid is never asserted for more than 1 consecutive cycle per packet. wb_* fields hold their last value while wb_valid = 0.
- Minimum load latency (accept at cycle N, ready high, response on the first WAIT cycle): handshake N+1, response N+2, wb_valid N+3.
- Reset during REQ or WAIT_RSP: the packet is dropped, no wb_valid, and a later stray response is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - Typedefs commit_t {mem_write, mem_read} and writeback_t {mem_to_reg, reg_write}, matching the commit interface structs.
  - State enum mem_state_e {IDLE, REQ, WAIT_RSP}.
  - REG_WIDTH and NUM_REGS constants.
- Single module; no sub-module. The timeout counter is inline and $clog2(RSP_TIMEOUT) bits wide.

Test Plan:
- ALU ops back-to-back: in_valid held 4 cycles, alu_result 0x10..0x13, reg_write = 1, dest 5..8 -> wb_valid 4 consecutive cycles carrying 0x10..0x13 / 5..8; in_ready stays 1.
- Store, ready delayed 3 cycles: addr 0x100, rb_data 0xDEADBEEF -> req fields stable 4 cycles, we = 1, in_ready = 0; one wb_valid after handshake with wb_reg_write = 0.
- Load, immediate ready, response 2 cycles into WAIT_RSP: rsp_data 0xCAFEF00D, mem_to_reg = 1, dest 3 -> wb_data 0xCAFEF00D, wb_reg_dest 3, single wb_valid pulse; the next in_valid is accepted only after return to IDLE.
- Load timeout with RSP_TIMEOUT = 4, no response -> return to IDLE after 4 WAIT cycles, err_timeout = 1 and sticky, wb_valid with wb_reg_write = 0; a stray response afterwards produces no wb_valid.
- Response exactly on the timeout cycle -> normal writeback, err_timeout remains 0.
- Reset asserted asynchronously mid WAIT_RSP -> all outputs 0 and in_ready = 1 immediately; a response arriving after reset release causes no wb_valid.
